// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings, FSM states,
// and the byte-lane helpers used by the alignment datapath.
package lsu_pkg;

  localparam logic [2:0] LSU_B  = 3'b000;
  localparam logic [2:0] LSU_H  = 3'b001;
  localparam logic [2:0] LSU_W  = 3'b010;
  localparam logic [2:0] LSU_BU = 3'b100;
  localparam logic [2:0] LSU_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_RESP
  } lsu_state_t;

  // Unsupported encodings count as misaligned so they complete without a bus access.
  function automatic logic lsu_misaligned(input logic [2:0] funct3, input logic [1:0] off);
    logic bad;
    case (funct3)
      LSU_B, LSU_BU: bad = 1'b0;
      LSU_H, LSU_HU: bad = off[0];
      LSU_W:         bad = (off != 2'b00);
      default:       bad = 1'b1;
    endcase
    return bad;
  endfunction

  function automatic logic [3:0] lsu_strobe(input logic [2:0] funct3, input logic [1:0] off);
    logic [3:0] strb;
    case (funct3[1:0])
      2'b00:   strb = 4'b0001 << off;
      2'b01:   strb = 4'b0011 << off;
      default: strb = 4'b1111;
    endcase
    return strb;
  endfunction

  // Replicating the store data across lanes lets the strobe alone pick the bytes.
  function automatic logic [31:0] lsu_replicate(input logic [2:0] funct3, input logic [31:0] wdata);
    logic [31:0] lanes;
    case (funct3[1:0])
      2'b00:   lanes = {4{wdata[7:0]}};
      2'b01:   lanes = {2{wdata[15:0]}};
      default: lanes = wdata;
    endcase
    return lanes;
  endfunction

  function automatic logic [31:0] lsu_extend(input logic [2:0] funct3, input logic [1:0] off,
                                             input logic [31:0] rdata);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    b = rdata[8*off +: 8];
    h = rdata[16*off[1] +: 16];
    case (funct3)
      LSU_B:   res = {{24{b[7]}}, b};
      LSU_BU:  res = {24'b0, b};
      LSU_H:   res = {{16{h[15]}}, h};
      LSU_HU:  res = {16'b0, h};
      default: res = rdata;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane logic: alignment check, strobes and lane replication
// on the request side, extraction and extension on the response side.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  req_funct3,
  input  logic [1:0]  req_off,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  rsp_funct3,
  input  logic [1:0]  rsp_off,
  input  logic [31:0] rsp_rdata,
  output logic        misaligned,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata_lanes,
  output logic [31:0] rdata_ext
);

  assign misaligned  = lsu_misaligned(req_funct3, req_off);
  assign wstrb       = lsu_strobe(req_funct3, req_off);
  assign wdata_lanes = lsu_replicate(req_funct3, req_wdata);
  assign rdata_ext   = lsu_extend(rsp_funct3, rsp_off, rsp_rdata);

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store initiator: accepts one load/store at a time, issues a single
// word-aligned memory request, and returns extended load data or an error.
module lsu_ctrl
  import lsu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_wdata,
  input  logic [2:0]  in_funct3,
  input  logic        in_store,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_addr,
  output logic        mem_wen,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_rdata,
  output logic        out_err
);

  lsu_state_t  state;
  logic [1:0]  off_q;
  logic [2:0]  funct3_q;
  logic        store_q;
  logic [31:0] addr_q;
  logic [3:0]  wstrb_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic        err_q;

  logic        misal_c;
  logic [3:0]  strb_c;
  logic [31:0] lanes_c;
  logic [31:0] ext_c;

  lsu_align u_align (
    .req_funct3  (in_funct3),
    .req_off     (in_addr[1:0]),
    .req_wdata   (in_wdata),
    .rsp_funct3  (funct3_q),
    .rsp_off     (off_q),
    .rsp_rdata   (mem_rdata),
    .misaligned  (misal_c),
    .wstrb       (strb_c),
    .wdata_lanes (lanes_c),
    .rdata_ext   (ext_c)
  );

  // Transaction FSM; request fields are captured on accept and held until the next accept.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      off_q    <= '0;
      funct3_q <= '0;
      store_q  <= 1'b0;
      addr_q   <= '0;
      wstrb_q  <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            off_q    <= in_addr[1:0];
            funct3_q <= in_funct3;
            store_q  <= in_store;
            addr_q   <= {in_addr[31:2], 2'b00};
            wstrb_q  <= in_store ? strb_c : 4'b0000;
            wdata_q  <= in_store ? lanes_c : '0;
            rdata_q  <= '0;
            err_q    <= misal_c;
            state    <= misal_c ? ST_RESP : ST_REQ;
          end
        end
        ST_REQ: begin
          if (mem_req_ready) state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (mem_resp_valid) begin
            if (!store_q) rdata_q <= ext_c;
            state <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (out_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready      = (state == ST_IDLE);
  assign mem_req_valid = (state == ST_REQ);
  assign mem_addr      = addr_q;
  assign mem_wen       = store_q;
  assign mem_wstrb     = wstrb_q;
  assign mem_wdata     = wdata_q;
  assign out_valid     = (state == ST_RESP);
  assign out_rdata     = rdata_q;
  assign out_err       = err_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Randomized bench for lsu_ctrl with a byte-arithmetic reference model.
module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_addr;
  logic [31:0] in_wdata;
  logic [2:0]  in_funct3;
  logic        in_store;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_addr;
  logic        mem_wen;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_resp_valid;
  logic [31:0] mem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_rdata;
  logic        out_err;

  int total = 0;
  int bad = 0;
  int hs_cnt = 0;
  int rq_cnt = 0;

  always #5 clk = ~clk;

  lsu_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_addr        (in_addr),
    .in_wdata       (in_wdata),
    .in_funct3      (in_funct3),
    .in_store       (in_store),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_addr       (mem_addr),
    .mem_wen        (mem_wen),
    .mem_wstrb      (mem_wstrb),
    .mem_wdata      (mem_wdata),
    .mem_resp_valid (mem_resp_valid),
    .mem_rdata      (mem_rdata),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_rdata      (out_rdata),
    .out_err        (out_err)
  );

  // Bus activity counters used to prove one request per transaction.
  always @(posedge clk) begin
    if (mem_req_valid) rq_cnt++;
    if (mem_req_valid && mem_req_ready) hs_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: access size in bytes, error rule, lanes and extension.
  function automatic int m_size(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic logic m_err(input logic [2:0] f3, input logic [31:0] addr);
    if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) return 1'b1;
    return (int'(addr[1:0]) % m_size(f3)) != 0;
  endfunction

  function automatic logic [3:0] m_strb(input logic [2:0] f3, input logic [31:0] addr, input logic st);
    int s;
    if (!st) return 4'b0000;
    s = ((1 << m_size(f3)) - 1) << int'(addr[1:0]);
    return s[3:0];
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] wd);
    logic [31:0] r;
    int sz;
    sz = m_size(f3);
    for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % sz) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] rd);
    logic [63:0] v;
    int sz;
    sz = m_size(f3);
    v = ({32'b0, rd} >> (8 * int'(addr[1:0]))) & ((64'd1 << (8 * sz)) - 64'd1);
    if (!f3[2] && sz < 4 && v[8*sz-1]) v = v - (64'd1 << (8 * sz));
    return v[31:0];
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic noise;
    in_valid  = 1'($urandom_range(0, 1));
    in_addr   = $urandom;
    in_wdata  = $urandom;
    in_funct3 = 3'($urandom);
    in_store  = 1'($urandom);
  endtask

  task automatic run_txn(input logic [31:0] addr, input logic [31:0] wd, input logic [2:0] f3,
                         input logic st, input logic [31:0] rd,
                         input int req_stall, input int resp_gap, input int out_stall);
    logic        e;
    logic [31:0] er;
    int          hs0;
    int          rq0;
    e   = m_err(f3, addr);
    er  = (e || st) ? 32'h0 : m_load(f3, addr, rd);
    hs0 = hs_cnt;
    rq0 = rq_cnt;
    check("idle_in_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b1; in_addr = addr; in_wdata = wd; in_funct3 = f3; in_store = st;
    tick();
    noise();
    if (!e) begin
      for (int i = 0; i <= req_stall; i++) begin
        check("req_valid", 32'(mem_req_valid), 32'd1);
        check("req_addr", mem_addr, {addr[31:2], 2'b00});
        check("req_wen", 32'(mem_wen), 32'(st));
        check("req_wstrb", 32'(mem_wstrb), 32'(m_strb(f3, addr, st)));
        if (st) check("req_wdata", mem_wdata, m_wdata(f3, wd));
        check("busy_in_ready", 32'(in_ready), 32'd0);
        mem_req_ready = (i == req_stall);
        mem_resp_valid = 1'b0;
        noise();
        tick();
      end
      mem_req_ready = 1'b0;
      for (int i = 0; i < resp_gap; i++) begin
        check("wait_no_req", 32'(mem_req_valid), 32'd0);
        check("wait_no_out", 32'(out_valid), 32'd0);
        noise();
        tick();
      end
      mem_resp_valid = 1'b1;
      mem_rdata = rd;
      tick();
      mem_resp_valid = 1'b0;
    end
    for (int i = 0; i <= out_stall; i++) begin
      check("out_valid", 32'(out_valid), 32'd1);
      check("out_err", 32'(out_err), 32'(e));
      check("out_rdata", out_rdata, er);
      check("resp_in_ready", 32'(in_ready), 32'd0);
      mem_rdata = $urandom;
      out_ready = (i == out_stall);
      noise();
      tick();
    end
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check("done_out_valid", 32'(out_valid), 32'd0);
    check("done_in_ready", 32'(in_ready), 32'd1);
    check("handshakes", 32'(hs_cnt - hs0), e ? 32'd0 : 32'd1);
    if (e) check("err_no_req", 32'(rq_cnt - rq0), 32'd0);
  endtask

  initial begin
    logic [2:0]  f3;
    logic [31:0] a;
    logic        st;
    logic [2:0]  f3_tab [8];
    f3_tab = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd2, 3'd3, 3'd6};

    rst_n = 1'b0; in_valid = 1'b0; in_addr = '0; in_wdata = '0; in_funct3 = '0; in_store = 1'b0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_rdata = '0; out_ready = 1'b0;
    tick();
    tick();
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_req_valid", 32'(mem_req_valid), 32'd0);
    check("rst_wen", 32'(mem_wen), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_err", 32'(out_err), 32'd0);
    check("rst_addr", mem_addr, 32'd0);
    check("rst_wstrb", 32'(mem_wstrb), 32'd0);
    check("rst_wdata", mem_wdata, 32'd0);
    check("rst_rdata", out_rdata, 32'd0);
    rst_n = 1'b1;
    tick();

    // Directed cases from the block's intended use.
    run_txn(32'h8000_0004, 32'h0, 3'b010, 1'b0, 32'hDEAD_BEEF, 0, 0, 0);
    run_txn(32'h8000_0003, 32'h0, 3'b000, 1'b0, 32'h80FF_0000, 0, 0, 0);
    run_txn(32'h8000_0003, 32'h0, 3'b100, 1'b0, 32'h80FF_0000, 0, 0, 0);
    run_txn(32'h8000_0002, 32'h0, 3'b101, 1'b0, 32'h80FF_0000, 0, 0, 0);
    run_txn(32'h8000_0001, 32'h1234_56AB, 3'b000, 1'b1, 32'h0, 0, 0, 0);
    run_txn(32'h8000_0002, 32'h1234_56AB, 3'b001, 1'b1, 32'h0, 0, 0, 0);
    run_txn(32'h8000_0002, 32'h0, 3'b010, 1'b0, 32'h1111_2222, 0, 0, 0);
    run_txn(32'h8000_0001, 32'h1234_56AB, 3'b001, 1'b1, 32'h0, 0, 0, 0);
    run_txn(32'h8000_0000, 32'hCAFE_F00D, 3'b010, 1'b1, 32'h0, 3, 1, 2);
    run_txn(32'h8000_0006, 32'h0, 3'b001, 1'b0, 32'h8001_7FFF, 3, 0, 2);

    // Reset while waiting for the response, then a stray response.
    in_valid = 1'b1; in_addr = 32'h8000_0010; in_funct3 = 3'b010; in_store = 1'b0;
    tick();
    in_valid = 1'b0;
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_req_valid", 32'(mem_req_valid), 32'd0);
    mem_resp_valid = 1'b1; mem_rdata = 32'h5555_AAAA;
    tick();
    mem_resp_valid = 1'b0;
    check("stray_out_valid", 32'(out_valid), 32'd0);
    check("stray_in_ready", 32'(in_ready), 32'd1);
    tick();
    check("stray_out_valid2", 32'(out_valid), 32'd0);
    run_txn(32'h8000_0010, 32'h0, 3'b010, 1'b0, 32'h0BAD_F00D, 0, 0, 0);

    // Randomized traffic, biased toward aligned addresses.
    for (int n = 0; n < 80; n++) begin
      f3 = f3_tab[$urandom_range(0, 7)];
      a  = $urandom;
      if ($urandom_range(0, 1) == 1) a[1:0] = a[1:0] & ((f3[1:0] == 2'b01) ? 2'b10 : (f3[1:0] == 2'b10) ? 2'b00 : 2'b11);
      st = (f3 <= 3'd2) ? 1'($urandom) : 1'b0;
      run_txn(a, $urandom, f3, st, $urandom,
              $urandom_range(0, 3), $urandom_range(0, 2), $urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lsu_ctrl.md
# lsu_ctrl

Core-side load/store initiator that drives the word-wide data-memory responder. Accepts one decoded RV32 load/store from the execute stage, checks alignment, issues a single word-aligned request with byte strobes, waits for the memory response, then extracts and sign/zero-extends load data and hands the result to writeback. Exactly one transaction is in flight; the block serialises the core's memory accesses.

## Interface
Parameters:
- none; data and address widths are fixed at 32.

Ports:
- clk  in  1  core clock; all state updates on rising edge
- rst_n  in  1  reset, synchronous, active-low
- in_valid  in  1  execute stage presents a request
- in_ready  out  1  high only in IDLE
- in_addr  in  32  byte address (rs1+imm)
- in_wdata  in  32  store data (rs2), LSB-justified
- in_funct3  in  3  RV32 funct3: 000 b, 001 h, 010 w, 100 bu, 101 hu
- in_store  in  1  1 = store, 0 = load
- mem_req_valid  out  1  request to memory
- mem_req_ready  in  1  memory accepts request
- mem_addr  out  32  word address, {in_addr[31:2], 2'b00}
- mem_wen  out  1  1 = write
- mem_wstrb  out  4  byte-lane enables (writes only; 0 on reads)
- mem_wdata  out  32  lane-replicated store data
- mem_resp_valid  in  1  response/read data valid, single-cycle pulse
- mem_rdata  in  32  full word read
- out_valid  out  1  result to writeback
- out_ready  in  1  writeback accepts result
- out_rdata  out  32  extended load data; 0 for stores and errors
- out_err  out  1  misaligned access, no memory access performed

## Operation
- States: IDLE, REQ, WAIT, RESP. Captured on accept: offset addr[1:0], funct3, store, word address, strobe, wdata.
- IDLE: in_ready=1. On in_valid: misaligned (h/hu with addr[0]=1, w with addr[1:0]≠0, or funct3 ∈ {011,110,111}) → RESP with out_err=1; otherwise → REQ.
- REQ: mem_req_valid=1 with stable addr/wen/wstrb/wdata until mem_req_ready; then → WAIT.
- WAIT: on mem_resp_valid → RESP, latching mem_rdata (loads). Responses in any other state are ignored.
- RESP: out_valid=1 held until out_ready; then → IDLE.
- Strobes: b → 4'b0001<<off; h → 4'b0011<<off; w → 4'b1111.
- Store data: b → {4{wdata[7:0]}}; h → {2{wdata[15:0]}}; w → wdata.
- Load extract: byte = rdata[8*off+:8], half = rdata[16*off[1]+:16]; b/h sign-extend, bu/hu zero-extend, w unchanged.

## Timing
- Reset (rst_n low at edge): state IDLE; in_ready=1 after reset; mem_req_valid, mem_wen, out_valid, out_err = 0; mem_addr, mem_wstrb, mem_wdata, out_rdata = 0. Reset mid-transaction aborts it; a later stray mem_resp_valid is ignored.
- Accept at edge T → mem_req_valid high from T+1. With mem_req_ready=1 at T+1 and mem_resp_valid at T+2, out_valid at T+3: minimum 3 cycles accept-to-result.
- Misaligned: accept at T → out_valid, out_err at T+1; mem_req_valid never asserts.
- mem_resp_valid in the same cycle as the request handshake is not legal; earliest is the following cycle.
- out_valid, out_rdata, out_err stable until out_ready. in_valid during non-IDLE is not accepted; back-to-back issue possible the cycle after the RESP handshake.

## Structure
- Shared package lsu_pkg: funct3 encodings (LSU_B, LSU_H, LSU_W, LSU_BU, LSU_HU), state enum, strobe/extend helper functions.
- One natural sub-module lsu_align: combinational strobe generation, store lane replication, load extraction/extension; FSM and registers stay in lsu_ctrl.

## Test plan
- lw addr 0x8000_0004, mem_rdata 0xDEADBEEF → mem_addr 0x8000_0004, wstrb 0, out_rdata 0xDEADBEEF, out_err 0, out_valid 3 cycles after accept.
- lb addr 0x8000_0003, mem_rdata 0x80FF_0000 → out_rdata 0xFFFF_FF80; lbu same → 0x0000_0080; lhu addr 0x...02 → 0x0000_80FF.
- sb addr 0x8000_0001, wdata 0x1234_56AB → mem_wen 1, wstrb 4'b0010, mem_wdata 0xABAB_ABAB; sh addr 0x...02 → wstrb 4'b1100, wdata 0x56AB_56AB.
- lw addr 0x8000_0002 and sh addr 0x...01 → out_err 1, out_rdata 0 at T+1, mem_req_valid never high.
- Backpressure: mem_req_ready low 3 cycles, out_ready low 2 cycles → request fields and output stable throughout, single transaction only, in_ready low until RESP handshake.
- rst_n low during WAIT, then mem_resp_valid pulse → IDLE, out_valid stays 0; next lw completes normally.
